// File: rtl/m602_pkg.sv
// Shared definitions for the m602 dual pulse generator: channel state
// encoding, default timing constants and counter sizing helper.
package m602_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Default timing in clk cycles at the 10 ns master clock.
   localparam int unsigned PW_LONG_DEF  = 11;
   localparam int unsigned PW_SHORT_DEF = 5;
   localparam int unsigned HOLDOFF_DEF  = 2;

   // Counter width able to hold (largest count - 1); never narrower than 1.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (m < 2) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/m602_channel.sv
// One pulse-generator channel: rising-edge trigger detect, IDLE/PULSE/HOLD
// state machine and a shared down-counter for pulse width and holdoff.
module m602_channel
   import m602_pkg::*;
#(
   parameter int unsigned PW_LONG  = PW_LONG_DEF,
   parameter int unsigned PW_SHORT = PW_SHORT_DEF,
   parameter int unsigned HOLDOFF  = HOLDOFF_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_trig,
   input  logic i_en,
   input  logic i_wsel,
   output logic o_pulse,
   output logic o_pulse_n
);

   localparam int unsigned CW = cnt_width(PW_LONG, PW_SHORT, HOLDOFF);

   // Counters are loaded with (cycles - 1) and the phase ends when they hit 0.
   localparam logic [CW-1:0] LOAD_LONG  = CW'(PW_LONG - 1);
   localparam logic [CW-1:0] LOAD_SHORT = CW'(PW_SHORT - 1);
   localparam logic [CW-1:0] LOAD_HOLD  = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_trig_d;
   logic            w_fire;

   // Accepted trigger: rising edge on the trigger with enable high this cycle.
   assign w_fire = i_trig & ~r_trig_d & i_en;

   // Previous-trigger register; resets high so a trigger held across reset
   // release is not mistaken for a fresh edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_trig_d <= 1'b1;
      else        r_trig_d <= i_trig;
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state and counter logic; width is latched into the counter on the
   // accepted edge so later width-select changes cannot affect the pulse.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         ST_IDLE: begin
            if (w_fire) begin
               w_state_nxt = ST_PULSE;
               w_cnt_nxt   = i_wsel ? LOAD_LONG : LOAD_SHORT;
            end
         end
         ST_PULSE: begin
            if (r_cnt == '0) begin
               // With no holdoff, IDLE itself provides the one low cycle.
               if (HOLDOFF == 0) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_HOLD;
                  w_cnt_nxt   = LOAD_HOLD;
               end
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         ST_HOLD: begin
            if (r_cnt == '0) w_state_nxt = ST_IDLE;
            else             w_cnt_nxt   = r_cnt - CW'(1);
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_pulse   = (r_state == ST_PULSE);
   assign o_pulse_n = ~o_pulse;

endmodule

// File: rtl/m602.sv
// m602: two independent retriggerable-inhibit pulse generators with
// selectable width and true/complement outputs.
module m602
   import m602_pkg::*;
#(
   parameter int unsigned PW_LONG  = PW_LONG_DEF,
   parameter int unsigned PW_SHORT = PW_SHORT_DEF,
   parameter int unsigned HOLDOFF  = HOLDOFF_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic D1,
   input  logic E1,
   input  logic F1,
   output logic H1,
   output logic J1,
   input  logic K1,
   input  logic L1,
   input  logic M1,
   output logic N1,
   output logic P1
);

   m602_channel #(
      .PW_LONG  (PW_LONG),
      .PW_SHORT (PW_SHORT),
      .HOLDOFF  (HOLDOFF)
   ) u_ch0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_trig    (D1),
      .i_en      (E1),
      .i_wsel    (F1),
      .o_pulse   (H1),
      .o_pulse_n (J1)
   );

   m602_channel #(
      .PW_LONG  (PW_LONG),
      .PW_SHORT (PW_SHORT),
      .HOLDOFF  (HOLDOFF)
   ) u_ch1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_trig    (K1),
      .i_en      (L1),
      .i_wsel    (M1),
      .o_pulse   (N1),
      .o_pulse_n (P1)
   );

endmodule

// File: doc/m602.md
M602 -- requirements
Module: m602

Interface
REQ-001 Parameter PW_LONG, default 11: long pulse width in clk cycles (110 ns at the 10 ns master clock).
REQ-002 Parameter PW_SHORT, default 5: short pulse width in clk cycles (50 ns).
REQ-003 Parameter HOLDOFF, default 2: minimum output-low cycles after a pulse before a new trigger is accepted.
REQ-004 clk  input  1  master simulation clock; all state advances on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 D1  input  1  channel 0 trigger; a rising edge requests a pulse.
REQ-007 E1  input  1  channel 0 enable (conditioning level); 1 = trigger permitted.
REQ-008 F1  input  1  channel 0 width select; 1 = PW_LONG, 0 = PW_SHORT.
REQ-009 H1  output  1  channel 0 pulse output, active high.
REQ-010 J1  output  1  channel 0 pulse output, complement of H1.
REQ-011 K1  input  1  channel 1 trigger.
REQ-012 L1  input  1  channel 1 enable.
REQ-013 M1  input  1  channel 1 width select.
REQ-014 N1  output  1  channel 1 pulse output, active high.
REQ-015 P1  output  1  channel 1 pulse output, complement of N1.

Function
REQ-016 Channels are fully independent; each SHALL implement the behaviour below with its own pins.
REQ-017 Inputs are already in the clk domain; no synchroniser SHALL be added; trigger edge = trig sampled 1 at edge n and 0 at edge n-1.
REQ-018 States: IDLE, PULSE, HOLD; each channel SHALL reset to IDLE.
REQ-019 IDLE -> PULSE when an edge is detected at edge n with enable = 1 at edge n; otherwise remain IDLE.
REQ-020 The width select SHALL be captured at edge n; later changes SHALL NOT alter the pulse in progress.
REQ-021 The output SHALL be high from edge n+1 through edge n+W, low after edge n+W+1; W = captured width.
REQ-022 PULSE -> HOLD after W cycles; HOLD -> IDLE after HOLDOFF cycles with the output low.
REQ-023 Trigger edges during PULSE or HOLD SHALL be ignored, not queued; an edge on the first IDLE cycle SHALL be accepted.
REQ-024 A trigger edge with enable = 0 SHALL be discarded; enable falling during PULSE SHALL NOT truncate the pulse.
REQ-025 HOLDOFF = 0 SHALL be legal: a pulse may be followed by a new pulse after one low cycle (the edge-detect minimum).
REQ-026 The complement output SHALL equal the inverse of the true output on every cycle, including during reset.
REQ-027 Width and holdoff counters SHALL be sized from the parameters; no wrap-around SHALL occur within a pulse.

Reset
REQ-028 While rst_n = 0: H1 = N1 = 0, J1 = P1 = 1, state IDLE, counters 0, asynchronously.
REQ-029 The previous-trigger register SHALL reset to 1, so a trigger held high across reset release does not fire.
REQ-030 Reset asserted mid-pulse SHALL terminate the pulse immediately; no pulse SHALL resume after release.

Structure
REQ-031 Package m602_pkg SHALL hold the state encoding (IDLE/PULSE/HOLD) and the default width and holdoff constants.
REQ-032 Sub-module m602_channel implements one channel (edge detect, FSM, counter); m602 instantiates it twice and wires the pins.

Verification
REQ-033 Defaults, F1 = 1, E1 = 1, D1 rises at edge 10 -> H1 high edges 11-21, low from edge 22; J1 = ~H1 throughout.
REQ-034 F1 = 0, D1 rises at edge 10, F1 toggles at edge 12 -> H1 high edges 11-15 only.
REQ-035 E1 = 0 at the D1 edge -> no pulse; E1 = 1, D1 re-rises at edge 40 -> pulse on edges 41-51.
REQ-036 Second D1 edge at edge 23 (HOLD) -> ignored; edge at 24 (first IDLE cycle) -> pulse on edges 25-35.
REQ-037 rst_n low at edge 15 mid-pulse -> H1 = 0 and J1 = 1 immediately; D1 held high across release -> no pulse.
REQ-038 Simultaneous edges on D1 and K1 with F1 = 1, M1 = 0 -> H1 11 cycles and N1 5 cycles, same start edge.
